// File: rtl/mp_addsub_if.sv
// Operand/result bundle between the Montgomery controller and the multi-precision
// adder/subtractor. The controller drives the request side; the adder drives the
// result side.
interface mp_addsub_if #(
    parameter int WIDTH = 1027
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0]   result;
    logic             done;
    logic             busy;

    modport master (
        output start, subtract, in_a, in_b,
        input  result, done, busy
    );

    modport slave (
        input  start, subtract, in_a, in_b,
        output result, done, busy
    );
endinterface

// File: rtl/mp_addsub_seq.sv
// Multi-precision adder/subtractor. It walks the operands one WORD-bit limb per
// cycle, LSB first, through a single WORD-bit adder with a registered carry.
// Subtraction is A + ~B + 1 over the zero-extended limb width. The top result bit
// is taken from the extended sum, so limb padding never alters the arithmetic.
module mp_addsub_seq #(
    parameter int WIDTH = 1027,
    parameter int WORD  = 64
) (
    input  logic        clk,
    input  logic        resetn,
    mp_addsub_if.slave  bus
);
    localparam int NWORDS = (WIDTH + WORD - 1) / WORD;
    localparam int EXT    = NWORDS * WORD;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [EXT-1:0]     a_q, a_d;
    logic [EXT-1:0]     b_q, b_d;
    logic [EXT-1:0]     acc_q, acc_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     res_q, res_d;

    logic [WORD-1:0]    limb_b;
    logic [WORD:0]      limb_sum;
    logic [EXT-1:0]     acc_shift;

    // Limb datapath: one WORD-bit add with carry-in, and the accumulator with the
    // new limb shifted in at the top. Concatenating before the shift avoids a
    // zero-width slice when there is only one limb.
    assign limb_b    = sub_q ? ~b_q[WORD-1:0] : b_q[WORD-1:0];
    assign limb_sum  = {1'b0, a_q[WORD-1:0]} + {1'b0, limb_b} + (WORD+1)'(carry_q);
    assign acc_shift = EXT'({limb_sum[WORD-1:0], acc_q} >> WORD);

    assign bus.result = res_q;
    assign bus.done   = (state_q == DONE);
    assign bus.busy   = (state_q != IDLE);

    // State register; reset clears every register so no X can reach the result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic: accept in IDLE, one limb per COMPUTE cycle, publish on DONE entry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = EXT'(bus.in_a);
                    b_d     = EXT'(bus.in_b);
                    sub_d   = bus.subtract;
                    carry_d = bus.subtract;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d   = acc_shift;
                carry_d = limb_sum[WORD];
                a_d     = a_q >> WORD;
                b_d     = b_q >> WORD;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // For subtract, the final carry is the inverse of the borrow.
                    // That only matters when the limbs exactly fill WIDTH bits.
                    res_d   = (WIDTH+1)'({limb_sum[WORD] ^ sub_q, acc_shift});
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Bench for mp_addsub_seq. It covers the default 1027/64 geometry and a small
// 10/4 geometry, where the limbs do not exactly fill the operand width. Results
// are compared against plain integer arithmetic.
module tb_mp_addsub_seq;
    localparam int BW    = 1027;
    localparam int BWORD = 64;
    localparam int BN    = (BW + BWORD - 1) / BWORD;
    localparam int SW    = 10;
    localparam int SWORD = 4;
    localparam int SN    = (SW + SWORD - 1) / SWORD;
    localparam int CW    = BW + 1;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mp_addsub_if #(.WIDTH(BW)) bif ();
    mp_addsub_if #(.WIDTH(SW)) sif ();

    mp_addsub_seq #(.WIDTH(BW), .WORD(BWORD)) u_big (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    mp_addsub_seq #(.WIDTH(SW), .WORD(SWORD)) u_small (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got_hi=%h got_lo=%h exp_hi=%h exp_lo=%h",
                     tag, got[CW-1:960], got[63:0], exp[CW-1:960], exp[63:0]);
        end
    endtask

    function automatic logic [BW-1:0] rnd_big();
        logic [BW-1:0] v = '0;
        for (int i = 0; i < (BW + 31) / 32; i++) v = (v << 32) | BW'($urandom);
        return v;
    endfunction

    // Result is defined modulo 2^(BW+1): the sum with its carry, or the wrapped difference.
    function automatic logic [CW-1:0] model_big(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                                input logic sub);
        logic [CW-1:0] ea = {1'b0, a};
        logic [CW-1:0] eb = {1'b0, b};
        return sub ? (ea - eb) : (ea + eb);
    endfunction

    function automatic int model_small(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                       input logic sub);
        return sub ? ((int'(a) - int'(b)) & ((1 << (SW + 1)) - 1)) : (int'(a) + int'(b));
    endfunction

    // One default-geometry operation. If poke is set, a rival start is pulsed mid-compute.
    task automatic op_big(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub,
                          input bit poke, input string tag);
        int k;
        logic [CW-1:0] exp;
        exp = model_big(a, b, sub);
        @(negedge clk);
        bif.start = 1'b1; bif.subtract = sub; bif.in_a = a; bif.in_b = b;
        @(negedge clk);
        bif.start = 1'b0; bif.subtract = ~sub; bif.in_a = rnd_big(); bif.in_b = rnd_big();
        chk({tag, "/busy"}, CW'(bif.busy), CW'(1'b1));
        k = 0;
        while (bif.done !== 1'b1 && k < BN + 4) begin
            @(negedge clk);
            k++;
            if (poke && k == 3) begin
                bif.start = 1'b1; bif.in_a = rnd_big(); bif.in_b = rnd_big();
            end else begin
                bif.start = 1'b0;
            end
        end
        bif.start = 1'b0;
        chk({tag, "/lat"}, CW'(k), CW'(BN));
        chk({tag, "/res"}, bif.result, exp);
        @(negedge clk);
        chk({tag, "/pulse"}, CW'(bif.done), '0);
        chk({tag, "/held"}, bif.result, exp);
    endtask

    task automatic op_small(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic sub);
        int k;
        int e;
        e = model_small(a, b, sub);
        @(negedge clk);
        sif.start = 1'b1; sif.subtract = sub; sif.in_a = a; sif.in_b = b;
        @(negedge clk);
        sif.start = 1'b0; sif.subtract = ~sub; sif.in_a = SW'($urandom); sif.in_b = SW'($urandom);
        k = 0;
        while (sif.done !== 1'b1 && k < SN + 4) begin
            @(negedge clk);
            k++;
        end
        chk("small/lat", CW'(k), CW'(SN));
        chk("small/res", CW'(sif.result), CW'(e));
    endtask

    initial begin
        logic [BW-1:0] ta, tb2, a1, b1, a2, b2;
        logic [SW-1:0] corner [11];
        int k;
        int ndone;
        n_checks = 0;
        n_fail   = 0;
        corner = '{10'd0, 10'd1, 10'd7, 10'd8, 10'd15, 10'd16, 10'd255, 10'd511,
                   10'd512, 10'd1022, 10'd1023};
        resetn = 1'b0;
        bif.start = 1'b0; bif.subtract = 1'b0; bif.in_a = '0; bif.in_b = '0;
        sif.start = 1'b0; sif.subtract = 1'b0; sif.in_a = '0; sif.in_b = '0;
        repeat (3) @(negedge clk);
        chk("rst/big_res", bif.result, '0);
        chk("rst/big_done", CW'(bif.done), '0);
        chk("rst/big_busy", CW'(bif.busy), '0);
        chk("rst/small_res", CW'(sif.result), '0);
        chk("rst/small_done", CW'(sif.done), '0);
        chk("rst/small_busy", CW'(sif.busy), '0);
        resetn = 1'b1;

        // Directed corner cases in the default geometry.
        ta = '1;
        op_big(ta, BW'(1), 1'b0, 1'b0, "add_carry");
        op_big(BW'(5), BW'(7), 1'b1, 1'b0, "sub_neg");
        ta = '0; ta[1026] = 1'b1; ta = ta + BW'(12345);
        op_big(ta, ta, 1'b1, 1'b0, "sub_eq");
        ta = '0; ta[64] = 1'b1;
        op_big(ta, BW'(1), 1'b1, 1'b0, "sub_borrow");
        for (int i = 0; i < 8; i++) begin
            ta  = rnd_big();
            tb2 = rnd_big();
            op_big(ta, tb2, 1'($urandom), 1'b0, "rand_big");
        end
        op_big(rnd_big(), rnd_big(), 1'b1, 1'b1, "poke_busy");

        // start held high: the second operation is accepted right after DONE.
        a1 = rnd_big(); b1 = rnd_big(); a2 = rnd_big(); b2 = rnd_big();
        @(negedge clk);
        bif.start = 1'b1; bif.subtract = 1'b0; bif.in_a = a1; bif.in_b = b1;
        @(negedge clk);
        k = 0;
        while (bif.done !== 1'b1 && k < BN + 4) begin
            @(negedge clk);
            k++;
        end
        chk("b2b/lat1", CW'(k), CW'(BN));
        chk("b2b/res1", bif.result, model_big(a1, b1, 1'b0));
        bif.in_a = a2; bif.in_b = b2; bif.subtract = 1'b1;
        @(negedge clk);
        chk("b2b/idle", CW'(bif.busy), '0);
        chk("b2b/held", bif.result, model_big(a1, b1, 1'b0));
        k = 0;
        while (bif.done !== 1'b1 && k < BN + 6) begin
            @(negedge clk);
            k++;
            if (k == 1) bif.start = 1'b0;
        end
        bif.start = 1'b0;
        chk("b2b/lat2", CW'(k), CW'(BN + 1));
        chk("b2b/res2", bif.result, model_big(a2, b2, 1'b1));

        // Reset after five limbs aborts the operation with no done pulse.
        @(negedge clk);
        bif.start = 1'b1; bif.subtract = 1'b0; bif.in_a = rnd_big(); bif.in_b = rnd_big();
        @(negedge clk);
        bif.start = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("midrst/res", bif.result, '0);
        chk("midrst/busy", CW'(bif.busy), '0);
        chk("midrst/done", CW'(bif.done), '0);
        ndone = 0;
        repeat (BN + 4) begin
            @(negedge clk);
            if (bif.done === 1'b1) ndone++;
        end
        chk("midrst/no_done", CW'(ndone), '0);
        op_big(BW'(3), BW'(4), 1'b0, 1'b0, "after_rst");

        // start in the same cycle as reset is not accepted.
        @(negedge clk);
        resetn = 1'b0; bif.start = 1'b1; bif.in_a = BW'(1); bif.in_b = BW'(1);
        @(negedge clk);
        resetn = 1'b1; bif.start = 1'b0;
        @(negedge clk);
        chk("rst_start/busy", CW'(bif.busy), '0);

        // Small geometry: corner grid plus random pairs, both operations.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 11; i++)
                for (int j = 0; j < 11; j++)
                    op_small(corner[i], corner[j], 1'(s));
        for (int i = 0; i < 200; i++)
            op_small(SW'($urandom), SW'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
